// File: rtl/nios2mypio_mul_pkg.sv
// Shared widths, FSM encoding and partial-product alignment for the
// sequential 32x32 multiplier built from one 16x16 stage.
package nios2mypio_mul_pkg;

  localparam int OPND_W = 32;
  localparam int HALF_W = 16;
  localparam int PP_W   = 32;
  localparam int RES_W  = 64;
  localparam int PP_NUM = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Element i is the left shift for the i-th issued partial product.
  localparam logic [PP_NUM-1:0][5:0] PP_SHIFT = {6'd32, 6'd16, 6'd16, 6'd0};

  function automatic logic [RES_W-1:0] pp_align(input logic [PP_W-1:0] pp,
                                                input logic [1:0] idx);
    logic [RES_W-1:0] ext;
    ext = {{(RES_W-PP_W){1'b0}}, pp};
    return ext << PP_SHIFT[idx];
  endfunction

endpackage

// File: rtl/nios2mypio_mul16_stage.sv
// Unsigned 16x16 multiplier with a single enabled output register.
module nios2mypio_mul16_stage
  import nios2mypio_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [PP_W-1:0]   p
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (ena) begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/nios2mypio_mul_seq_arbiter.sv
// Two-requester round-robin front end for a 4-pass sequential 32x32 multiply.
// Handshake: a request/response transfers on a rising edge where valid and ready are both high.
module nios2mypio_mul_seq_arbiter
  import nios2mypio_mul_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic              req1_valid,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic [1:0]        state_dbg
);

  logic [1:0]        state;
  logic              ptr;
  logic              owner;
  logic [OPND_W-1:0] op_a;
  logic [OPND_W-1:0] op_b;
  logic [1:0]        idx;
  logic [RES_W-1:0]  acc;
  logic [PP_W-1:0]   pp;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              handshake;
  logic              stage_ena;
  logic [HALF_W-1:0] stage_a;
  logic [HALF_W-1:0] stage_b;

  // The pointer only breaks ties; a lone valid requester always wins.
  assign grant0     = req0_valid & (~req1_valid | ~ptr);
  assign grant1     = req1_valid & (~req0_valid | ptr);
  assign req0_ready = (state == ST_IDLE) & grant0;
  assign req1_ready = (state == ST_IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign handshake  = (state == ST_RESP) & rsp_ready[owner];

  assign stage_ena = (state == ST_MUL);
  assign stage_a   = idx[1] ? op_a[OPND_W-1:HALF_W] : op_a[HALF_W-1:0];
  assign stage_b   = idx[0] ? op_b[OPND_W-1:HALF_W] : op_b[HALF_W-1:0];

  nios2mypio_mul16_stage u_stage (
    .clk   (clk),
    .rst_n (reset_n),
    .ena   (stage_ena),
    .a     (stage_a),
    .b     (stage_b),
    .p     (pp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a  <= req1_ready ? req1_a : req0_a;
            op_b  <= req1_ready ? req1_b : req0_b;
            owner <= req1_ready;
            ptr   <= ~req1_ready;
            acc   <= '0;
            idx   <= '0;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          // The stage output lags issue by one cycle, so accumulate the previous index.
          if (idx != 2'd0) begin
            acc <= acc + pp_align(pp, idx - 2'd1);
          end
          if (idx == 2'd3) begin
            state <= ST_FLUSH;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        ST_FLUSH: begin
          acc   <= acc + pp_align(pp, idx);
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (handshake) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (handshake && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rsp_valid = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = (state == ST_RESP) ? acc : '0;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_nios2mypio_mul_seq_arbiter.sv
// Bench for the round-robin sequential multiplier; a second instance with a
// 2-bit counter shares all stimulus to observe counter saturation.
module tb_nios2mypio_mul_seq_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic        busy;
  logic [15:0] op_count;
  logic [1:0]  state_dbg;

  logic        sat_req0_ready, sat_req1_ready;
  logic [1:0]  sat_rsp_valid;
  logic [63:0] sat_rsp_data;
  logic        sat_busy;
  logic [1:0]  sat_op_count;
  logic [1:0]  sat_state_dbg;

  int tests_run;
  int tests_failed;
  int cyc;
  int exp_count;

  logic [63:0] exp_q[$];
  logic        exp_id_q[$];
  int          exp_cyc_q[$];

  nios2mypio_mul_seq_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count), .state_dbg(state_dbg)
  );

  nios2mypio_mul_seq_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(sat_req0_ready), .req1_ready(sat_req1_ready),
    .rsp_valid(sat_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(sat_rsp_data),
    .busy(sat_busy), .op_count(sat_op_count), .state_dbg(sat_state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic reset_dut();
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready  = 2'b00;
    exp_count  = 0;
    exp_q.delete();
    exp_id_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // driver: present a request and wait for it to be accepted
  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp);
    int n;
    logic rdy;
    n = 0;
    if (id) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    #1;
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      rdy = id ? req1_ready : req0_ready;
      n++;
    end
    tests_run++;
    if (!rdy) begin
      tests_failed++;
      $display("FAIL send_timeout id=%0d ready never rose within 20 cycles", id);
    end else if (req0_ready & req1_ready) begin
      tests_failed++;
      $display("FAIL single_ready got both readies high, required one");
    end
    if (rdy) begin
      exp_q.push_back(exp);
      exp_id_q.push_back(id);
      exp_cyc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    // Scramble the operands after acceptance; the result must not change.
    if (id) begin
      req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom;
    end else begin
      req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom;
    end
  endtask

  // scoreboard: pop expected result, check response, hold, then handshake
  task automatic recv(input int hold);
    int n;
    logic [63:0] e;
    logic        eid;
    int          ec;
    logic [1:0]  ev;
    int          es;
    n = 0;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL recv_empty no expected result queued");
      return;
    end
    e   = exp_q.pop_front();
    eid = exp_id_q.pop_front();
    ec  = exp_cyc_q.pop_front();
    ev  = eid ? 2'b10 : 2'b01;
    while (rsp_valid == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid !== ev) begin
      tests_failed++;
      $display("FAIL rsp_valid got %b required %b", rsp_valid, ev);
    end
    tests_run++;
    if (rsp_data !== e) begin
      tests_failed++;
      $display("FAIL rsp_data got %h required %h", rsp_data, e);
    end
    tests_run++;
    if (cyc - ec != 5) begin
      tests_failed++;
      $display("FAIL latency got %0d cycles required 5", cyc - ec);
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = eid ? 2'b01 : 2'b10;
      @(negedge clk); #1;
      tests_run++;
      if (rsp_valid !== ev || rsp_data !== e || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_stable got valid=%b data=%h busy=%b rdy=%b%b required valid=%b data=%h busy=1 rdy=00",
                 rsp_valid, rsp_data, busy, req1_ready, req0_ready, ev, e);
      end
    end
    rsp_ready = eid ? 2'b10 : 2'b01;
    #1;
    tests_run++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_reaccept got rdy=%b%b during handshake required 00", req1_ready, req0_ready);
    end
    @(negedge clk);
    rsp_ready = 2'b00;
    exp_count++;
    es = (exp_count > 3) ? 3 : exp_count;
    tests_run++;
    if (rsp_valid !== 2'b00 || rsp_data !== 64'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_handshake got valid=%b data=%h busy=%b required 00/0/0",
               rsp_valid, rsp_data, busy);
    end
    tests_run++;
    if (op_count !== exp_count[15:0] || sat_op_count !== es[1:0]) begin
      tests_failed++;
      $display("FAIL op_count got %0d/%0d required %0d/%0d", op_count, sat_op_count, exp_count, es);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(negedge clk); #1;
    tests_run++;
    if (rsp_valid !== 2'b00 || rsp_data !== 64'd0 || busy !== 1'b0 ||
        op_count !== 16'd0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got valid=%b data=%h busy=%b cnt=%0d st=%0d required all 0",
               rsp_valid, rsp_data, busy, op_count, state_dbg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_count = 0;
    req1_valid = 1'b1;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_cycle_ready got rdy=%b%b required 10", req1_ready, req0_ready);
    end
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    reset_dut();
    send(1'b0, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008);
    recv(0);
  endtask

  task automatic test_max();
    send(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    recv(1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        id;
    for (int i = 0; i < 4; i++) begin
      a  = $urandom;
      b  = $urandom;
      id = 1'($urandom_range(0, 1));
      send(id, a, b, {32'd0, a} * {32'd0, b});
      recv($urandom_range(0, 3));
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    send(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, {32'd0, 32'h1234_5678} * {32'd0, 32'h9ABC_DEF0});
    req0_a = 32'h0000_FFFF; req0_b = 32'h0001_0000; req0_valid = 1'b1;
    recv(10);
    send(1'b0, 32'h0000_FFFF, 32'h0001_0000, 64'h0000_0000_FFFF_0000);
    recv(0);
  endtask

  task automatic test_contention();
    int n;
    logic w;
    reset_dut();
    req0_a = 32'd3; req0_b = 32'd5; req1_a = 32'd7; req1_b = 32'hFFFF_0001;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!(req0_ready | req1_ready) && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      w = req1_ready;
      tests_run++;
      if (!(req0_ready ^ req1_ready) || w !== k[0]) begin
        tests_failed++;
        $display("FAIL grant_order op %0d got rdy=%b%b required grant %0d", k, req1_ready, req0_ready, k[0]);
      end
      exp_q.push_back(w ? 64'h0000_0006_FFF9_0007 : 64'd15);
      exp_id_q.push_back(w);
      exp_cyc_q.push_back(cyc + 1);
      @(negedge clk);
      recv(0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests_run++;
    if (op_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL contention_count got %0d required 4", op_count);
    end
  endtask

  task automatic test_reset_mid_op();
    reset_dut();
    send(1'b0, 32'd10, 32'd20, 64'd200);
    recv(0);
    send(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 64'd0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (state_dbg !== 2'd1) begin
      tests_failed++;
      $display("FAIL mid_op_state got %0d required 1", state_dbg);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 2'b00 || rsp_data !== 64'd0 || busy !== 1'b0 || op_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_op_reset got valid=%b data=%h busy=%b cnt=%0d required 0/0/0/0",
               rsp_valid, rsp_data, busy, op_count);
    end
    exp_q.delete(); exp_id_q.delete(); exp_cyc_q.delete();
    exp_count = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || op_count !== 16'd0) begin
        tests_failed++;
        $display("FAIL no_rsp_after_reset cycle %0d got valid=%b busy=%b cnt=%0d required 00/0/0",
                 i, rsp_valid, busy, op_count);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] a, b;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom_range(0, 65535);
      send(i[0], a, b, {32'd0, a} * {32'd0, b});
      recv(0);
    end
    tests_run++;
    if (sat_op_count !== 2'd3 || op_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL saturation got %0d/%0d required 3/5", sat_op_count, op_count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_count    = 0;
    test_reset();
    test_single();
    test_max();
    test_random();
    test_backpressure();
    test_contention();
    test_reset_mid_op();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
